// File: rtl/mem_copy_engine.sv
// mem_copy_engine: forward word-by-word memory copy (read cycle then write cycle per word).
module mem_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [15:0]       WordCount,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemReadData
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [15:0]         rem_q, rem_d;
  logic [DATA_W-1:0]   buf_q, buf_d, wdata_q, wdata_d;
  logic                busy_q, busy_d, done_q, done_d, we_q, we_d;
  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (Start) begin
        src_d   = SrcAddr;
        dst_d   = DstAddr;
        rem_d   = WordCount;
        state_d = (WordCount == 16'd0) ? FIN : READ;
      end
      READ: begin
        buf_d   = MemReadData;
        state_d = WRITE;
      end
      WRITE: begin
        src_d   = src_q + ADDR_W'(2);
        dst_d   = dst_q + ADDR_W'(2);
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? FIN : READ;
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == READ) || (state_d == WRITE);
    done_d  = state_d == FIN;
    we_d    = state_d == WRITE;
    addr_d  = (state_d == READ) ? src_d : (state_d == WRITE) ? dst_d : '0;
    wdata_d = (state_d == WRITE) ? buf_d : '0;
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign MemWrite     = we_q;
  assign MemAddress   = addr_q;
  assign MemWriteData = wdata_q;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: table-driven copy vectors against a byte-array memory model, plus reset-abort sequence.
module tb_mem_copy_engine;
  logic        Clock = 1'b0, Reset = 1'b1, Start = 1'b0;
  logic [15:0] SrcAddr = '0, DstAddr = '0, WordCount = '0;
  logic        Busy, Done, MemWrite;
  logic [15:0] MemAddress, MemWriteData, MemReadData;
  logic [7:0]  mem [0:65535];
  int          pass_n = 0, total_n = 0;
  typedef struct {
    logic [15:0] src, dst, cnt;
    logic [15:0] src_w [4];
    logic [15:0] exp_w [4];
    int          nchk;
    bit          restart;
  } vec_t;
  vec_t vecs [6];

  mem_copy_engine #(.ADDR_W(16), .DATA_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
    .WordCount(WordCount), .Busy(Busy), .Done(Done), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;
  assign MemReadData = {mem[16'(MemAddress + 16'd1)], mem[MemAddress]};
  always @(negedge Clock) if (MemWrite) begin
    mem[MemAddress] = MemWriteData[7:0];
    mem[16'(MemAddress + 16'd1)] = MemWriteData[15:8];
  end

  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    mem[a] = d[7:0];
    mem[16'(a + 16'd1)] = d[15:8];
  endtask

  function automatic logic [15:0] rd_word(input logic [15:0] a);
    return {mem[16'(a + 16'd1)], mem[a]};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  function automatic vec_t mk(input logic [15:0] s, d, c, s0, s1, s2, s3, e0, e1, e2, e3,
                              input int n, input bit r);
    vec_t v;
    v.src = s; v.dst = d; v.cnt = c;
    v.src_w[0] = s0; v.src_w[1] = s1; v.src_w[2] = s2; v.src_w[3] = s3;
    v.exp_w[0] = e0; v.exp_w[1] = e1; v.exp_w[2] = e2; v.exp_w[3] = e3;
    v.nchk = n; v.restart = r;
    return v;
  endfunction

  task automatic run(input vec_t v, input int idx);
    int busy_n = 0, done_n = 0, done_cyc = 0, wr_n = 0, n = int'(v.cnt);
    clear_mem();
    for (int i = 0; i < 4; i++) wr_word(16'(v.src + 16'(2 * i)), v.src_w[i]);
    @(posedge Clock); #1;
    SrcAddr = v.src; DstAddr = v.dst; WordCount = v.cnt; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int k = 1; k <= 2 * n + 4; k++) begin
      if (v.restart && k == 2) begin
        Start = 1'b1; SrcAddr = 16'h0010; DstAddr = 16'h0900; WordCount = 16'd5;
      end
      if (v.restart && k == 3) Start = 1'b0;
      busy_n += int'(Busy);
      wr_n += int'(MemWrite);
      if (Done) begin
        done_n++;
        if (done_cyc == 0) done_cyc = k;
        chk($sformatf("v%0d fin_addr", idx), int'(MemAddress), 0);
      end
      @(posedge Clock); #1;
    end
    chk($sformatf("v%0d busy_cycles", idx), busy_n, 2 * n);
    chk($sformatf("v%0d done_cycle", idx), done_cyc, 2 * n + 1);
    chk($sformatf("v%0d done_pulses", idx), done_n, 1);
    chk($sformatf("v%0d write_cycles", idx), wr_n, n);
    for (int i = 0; i < v.nchk; i++)
      chk($sformatf("v%0d word%0d", idx, i), int'(rd_word(16'(v.dst + 16'(2 * i)))), int'(v.exp_w[i]));
  endtask

  initial begin
    int done_n;
    vecs[0] = mk(16'h0010, 16'h0100, 16'd3, 16'hABCD, 16'h1234, 16'h5678, 16'h0,
                 16'hABCD, 16'h1234, 16'h5678, 16'h0, 3, 1'b0);
    vecs[1] = mk(16'h0020, 16'h0030, 16'd0, 16'h5555, 16'h6666, 16'h0, 16'h0,
                 16'h0000, 16'h0, 16'h0, 16'h0, 1, 1'b0);
    vecs[2] = mk(16'hFFFE, 16'h0200, 16'd2, 16'hBEEF, 16'h1234, 16'h0, 16'h0,
                 16'hBEEF, 16'h1234, 16'h0, 16'h0, 2, 1'b0);
    vecs[3] = mk(16'h0000, 16'h0002, 16'd2, 16'h1111, 16'h2222, 16'h0, 16'h0,
                 16'h1111, 16'h1111, 16'h0, 16'h0, 2, 1'b0);
    vecs[4] = mk(16'h0301, 16'h0401, 16'd2, 16'hA1B2, 16'hC3D4, 16'h0, 16'h0,
                 16'hA1B2, 16'hC3D4, 16'h0, 16'h0, 2, 1'b0);
    vecs[5] = mk(16'h0700, 16'h0800, 16'd2, 16'h7001, 16'h7002, 16'h0, 16'h0,
                 16'h7001, 16'h7002, 16'h0, 16'h0, 2, 1'b1);
    clear_mem();
    #2;
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_memwrite", int'(MemWrite), 0);
    chk("rst_addr", int'(MemAddress), 0);
    chk("rst_wdata", int'(MemWriteData), 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) run(vecs[i], i);
    // Reset landing in the second write of a 4-word copy: first word stays, nothing else lands.
    clear_mem();
    for (int i = 0; i < 4; i++) wr_word(16'(16'h0500 + 16'(2 * i)), 16'(16'h0A01 + i));
    @(posedge Clock); #1;
    SrcAddr = 16'h0500; DstAddr = 16'h0600; WordCount = 16'd4; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int k = 1; k < 4; k++) begin @(posedge Clock); #1; end
    chk("abort_pre_memwrite", int'(MemWrite), 1);
    Reset = 1'b1;
    #1;
    chk("abort_memwrite", int'(MemWrite), 0);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_addr", int'(MemAddress), 0);
    done_n = 0;
    for (int k = 0; k < 3; k++) begin
      done_n += int'(Done);
      @(posedge Clock); #1;
    end
    Reset = 1'b0;
    chk("abort_done_pulses", done_n + int'(Done), 0);
    chk("abort_word0", int'(rd_word(16'h0600)), 16'h0A01);
    chk("abort_word1", int'(rd_word(16'h0602)), 16'h0000);
    SrcAddr = 16'h0504; DstAddr = 16'h0700; WordCount = 16'd1; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    chk("post_rst_busy", int'(Busy), 1);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    chk("post_rst_done", int'(Done), 1);
    chk("post_rst_word", int'(rd_word(16'h0700)), 16'h0A03);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
